// File: rtl/march_address_sequencer_pkg.sv
// Shared widths, address-mode codes, direction codes and FSM encoding for the
// PMBIST march address sequencer.
package march_address_sequencer_pkg;

  localparam int unsigned TASW  = 8;
  localparam int unsigned ADMDW = 4;
  localparam int unsigned OPW   = 3;

  localparam logic [ADMDW-1:0] ADMD_AC  = ADMDW'(0);
  localparam logic [ADMDW-1:0] ADMD_GC  = ADMDW'(1);
  localparam logic [ADMDW-1:0] ADMD_2I0 = ADMDW'(2);
  localparam logic [ADMDW-1:0] ADMD_2I1 = ADMDW'(3);
  localparam logic [ADMDW-1:0] ADMD_2I2 = ADMDW'(4);
  localparam logic [ADMDW-1:0] ADMD_2I3 = ADMDW'(5);
  localparam logic [ADMDW-1:0] ADMD_2I4 = ADMDW'(6);
  localparam logic [ADMDW-1:0] ADMD_2I5 = ADMDW'(7);
  localparam logic [ADMDW-1:0] ADMD_2I6 = ADMDW'(8);
  localparam logic [ADMDW-1:0] ADMD_2I7 = ADMDW'(9);

  localparam logic ADDR_UP   = 1'b0;
  localparam logic ADDR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } seq_state_e;

  // First TAS of an element: bottom of the space going up, top going down.
  function automatic logic [TASW-1:0] tas_first(input logic updwn);
    return (updwn == ADDR_DOWN) ? {TASW{1'b1}} : {TASW{1'b0}};
  endfunction

endpackage

// File: rtl/march_address_sequencer_tas_updown_counter.sv
// Loadable TAS up/down counter with enable; tc flags the last address in the
// current counting direction.
module march_address_sequencer_tas_updown_counter
  import march_address_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [TASW-1:0] load_val,
  input  logic            en,
  input  logic            dn,
  output logic [TASW-1:0] cnt,
  output logic            tc
);

  logic [TASW-1:0] cnt_q;
  logic [TASW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = dn ? (cnt_q - TASW'(1)) : (cnt_q + TASW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = dn ? (cnt_q == {TASW{1'b0}}) : (cnt_q == {TASW{1'b1}});

endmodule

// File: rtl/march_address_sequencer.sv
// Sequences one march element over the full TAS space, holding each address
// for (ops_cfg+1) acknowledged operations.
module march_address_sequencer
  import march_address_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADMDW-1:0] admd_cfg,
  input  logic             updwn_cfg,
  input  logic [OPW-1:0]   ops_cfg,
  input  logic             op_ack,
  output logic [TASW-1:0]  tas_out,
  output logic [ADMDW-1:0] admd_out,
  output logic             updwn_out,
  output logic             addr_valid,
  output logic [OPW-1:0]   op_idx,
  output logic             last_addr,
  output logic             busy,
  output logic             done
);

  seq_state_e       state_q, state_d;
  logic [OPW-1:0]   op_idx_q, op_idx_d;
  logic [OPW-1:0]   ops_q, ops_d;
  logic [ADMDW-1:0] admd_q, admd_d;
  logic             updwn_q, updwn_d;
  logic             busy_q, busy_d;
  logic             addr_valid_q, addr_valid_d;
  logic             done_q, done_d;

  logic             tas_load;
  logic [TASW-1:0]  tas_load_val;
  logic             tas_en;
  logic [TASW-1:0]  tas_cnt;
  logic             tas_tc;

  march_address_sequencer_tas_updown_counter u_tas_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (tas_load),
    .load_val (tas_load_val),
    .en       (tas_en),
    .dn       (updwn_q == ADDR_DOWN),
    .cnt      (tas_cnt),
    .tc       (tas_tc)
  );

  // Next-state, config latch and op/address stepping.
  always_comb begin
    state_d      = state_q;
    op_idx_d     = op_idx_q;
    ops_d        = ops_q;
    admd_d       = admd_q;
    updwn_d      = updwn_q;
    busy_d       = busy_q;
    addr_valid_d = addr_valid_q;
    done_d       = 1'b0;
    tas_load     = 1'b0;
    tas_load_val = '0;
    tas_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          admd_d       = admd_cfg;
          updwn_d      = updwn_cfg;
          ops_d        = ops_cfg;
          op_idx_d     = '0;
          tas_load     = 1'b1;
          tas_load_val = tas_first(updwn_cfg);
          busy_d       = 1'b1;
          addr_valid_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (op_ack) begin
          if (op_idx_q != ops_q) begin
            op_idx_d = op_idx_q + OPW'(1);
          end else if (!tas_tc) begin
            op_idx_d = '0;
            tas_en   = 1'b1;
          end else begin
            // Final op at final address: tas/op_idx freeze until next start.
            busy_d       = 1'b0;
            addr_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_idx_q     <= '0;
      ops_q        <= '0;
      admd_q       <= ADMD_2I0;
      updwn_q      <= ADDR_UP;
      busy_q       <= 1'b0;
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_idx_q     <= op_idx_d;
      ops_q        <= ops_d;
      admd_q       <= admd_d;
      updwn_q      <= updwn_d;
      busy_q       <= busy_d;
      addr_valid_q <= addr_valid_d;
      done_q       <= done_d;
    end
  end

  assign tas_out    = tas_cnt;
  assign admd_out   = admd_q;
  assign updwn_out  = updwn_q;
  assign op_idx     = op_idx_q;
  assign busy       = busy_q;
  assign addr_valid = addr_valid_q;
  assign done       = done_q;
  assign last_addr  = busy_q & tas_tc;

endmodule

// File: tb/tb_march_address_sequencer.sv
// Bench for march_address_sequencer: each element's expected (tas, op_idx)
// sequence is listed up front and consumed one entry per observed ack.
module tb_march_address_sequencer;
  import march_address_sequencer_pkg::*;

  localparam int NADDR = 1 << TASW;

  logic             clk;
  logic             rst;
  logic             start;
  logic [ADMDW-1:0] admd_cfg;
  logic             updwn_cfg;
  logic [OPW-1:0]   ops_cfg;
  logic             op_ack;
  logic [TASW-1:0]  tas_out;
  logic [ADMDW-1:0] admd_out;
  logic             updwn_out;
  logic             addr_valid;
  logic [OPW-1:0]   op_idx;
  logic             last_addr;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_tas[$];
  int exp_op[$];

  march_address_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .admd_cfg   (admd_cfg),
    .updwn_cfg  (updwn_cfg),
    .ops_cfg    (ops_cfg),
    .op_ack     (op_ack),
    .tas_out    (tas_out),
    .admd_out   (admd_out),
    .updwn_out  (updwn_out),
    .addr_valid (addr_valid),
    .op_idx     (op_idx),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_tas"},        tas_out, 0);
    chk({pfx, "_op_idx"},     op_idx, 0);
    chk({pfx, "_admd"},       admd_out, ADMD_2I0);
    chk({pfx, "_updwn"},      updwn_out, ADDR_UP);
    chk({pfx, "_addr_valid"}, addr_valid, 0);
    chk({pfx, "_busy"},       busy, 0);
    chk({pfx, "_done"},       done, 0);
    chk({pfx, "_last_addr"},  last_addr, 0);
  endtask

  // ack_mode: 0 held high, 1 toggling, 2 random. iso scrambles start/config
  // during the run. abort_at >= 0 asserts rst once that many acks were taken.
  task automatic run_element(input logic dir, input logic [ADMDW-1:0] admd, input int ops,
                             input int ack_mode, input bit iso, input int abort_at);
    int acks;
    int cyc;
    int budget;
    int last_a;
    bit tog;
    exp_tas.delete();
    exp_op.delete();
    for (int k = 0; k < NADDR; k++) begin
      for (int o = 0; o <= ops; o++) begin
        exp_tas.push_back(dir == ADDR_UP ? k : NADDR - 1 - k);
        exp_op.push_back(o);
      end
    end
    last_a = (dir == ADDR_UP) ? NADDR - 1 : 0;
    start = 1'b1; admd_cfg = admd; updwn_cfg = dir; ops_cfg = OPW'(ops); op_ack = 1'b0;
    step();
    start = 1'b0;
    acks = 0; cyc = 0; tog = 1'b1;
    budget = NADDR * (ops + 1) * 4 + 100;
    while (exp_tas.size() > 0) begin
      if (cyc >= budget) begin
        chk("run_timeout_remaining", exp_tas.size(), 0);
        break;
      end
      chk("busy", busy, 1);
      chk("addr_valid", addr_valid, 1);
      chk("tas", tas_out, exp_tas[0]);
      chk("op_idx", op_idx, exp_op[0]);
      chk("last_addr", last_addr, exp_tas[0] == last_a);
      chk("admd_hold", admd_out, admd);
      chk("updwn_hold", updwn_out, dir);
      if (abort_at >= 0 && acks == abort_at) begin
        rst = 1'b1; op_ack = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; op_ack = 1'b0; start = 1'b0;
        chk_reset_outputs("abort");
        step();
        chk("abort_no_done", done, 0);
        chk("abort_no_busy", busy, 0);
        return;
      end
      case (ack_mode)
        0:       op_ack = 1'b1;
        1:       begin op_ack = tog; tog = ~tog; end
        default: op_ack = ($urandom_range(0, 3) != 0);
      endcase
      if (iso) begin
        start     = 1'($urandom);
        admd_cfg  = ADMDW'($urandom);
        updwn_cfg = 1'($urandom);
        ops_cfg   = OPW'($urandom);
      end
      step();
      cyc++;
      if (op_ack) begin
        void'(exp_tas.pop_front());
        void'(exp_op.pop_front());
        acks++;
      end
    end
    op_ack = 1'b0; start = 1'b0;
    chk("done_pulse", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_addr_valid", addr_valid, 0);
    chk("fin_last_addr", last_addr, 0);
    chk("fin_tas", tas_out, last_a);
    chk("fin_op_idx", op_idx, ops);
    // A start in the done cycle must be ignored.
    start = 1'b1; updwn_cfg = ~dir; admd_cfg = ~admd;
    step();
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("fin_start_ignored_busy", busy, 0);
    chk("fin_start_ignored_updwn", updwn_out, dir);
    chk("fin_start_ignored_admd", admd_out, admd);
    chk("idle_tas_kept", tas_out, last_a);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; admd_cfg = ADMD_GC; updwn_cfg = ADDR_DOWN;
    ops_cfg = OPW'(5); op_ack = 1'b1;
    step();
    step();
    chk_reset_outputs("rst");
    rst = 1'b0; start = 1'b0; op_ack = 1'b0;
    step();
    chk("rst_start_no_busy", busy, 0);
    chk("rst_start_no_valid", addr_valid, 0);

    run_element(ADDR_UP,   ADMD_2I0, 0, 0, 1'b0, -1);
    run_element(ADDR_DOWN, ADMD_2I3, 2, 1, 1'b0, -1);
    run_element(ADDR_UP,   ADMD_GC,  1, 2, 1'b1, -1);
    // Abort at tas=0x40, op_idx=1 going down with 3 ops/address.
    run_element(ADDR_DOWN, ADMD_AC,  2, 0, 1'b0, (NADDR - 1 - 'h40) * 3 + 1);
    run_element(ADDR_UP,   ADMD_2I7, 3, 2, 1'b0, -1);
    for (int r = 0; r < 2; r++) begin
      run_element(1'($urandom), ADMDW'($urandom_range(0, 9)),
                  int'($urandom_range(0, (1 << OPW) - 1)), 2, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/march_address_sequencer.md
Name: march_address_sequencer

Overview:
- Sequences one march element across the full memory address space for the PMBIST engine.
- Owns the true-address-state (TAS) counter and drives `tas`, address mode and up/down into the existing combinational address generator.
- Holds each address for a programmable number of read/write operations. The element executor acknowledges each operation.
- Started once per march element by the BIST top controller; reports done when the last operation at the last address is accepted.

Parameters:
- TASW, `ADDR_WIDTH (8): width of the TAS counter and of tas_out.
- ADMDW, `ADMD_WIDTH (4): width of the address-mode code (`ADMD_AC, `ADMD_GC, `ADMD_2I0..`ADMD_2I7).
- OPW, 3: width of the operation index; up to 2^OPW operations per address.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin a march element. Ignored while busy.
- admd_cfg  in  ADMDW  address mode for this element; latched on accepted start.
- updwn_cfg  in  1  `ADDR_UP / `ADDR_DOWN; latched on accepted start.
- ops_cfg  in  OPW  number of operations per address, minus 1; latched on accepted start.
- op_ack  in  1  element executor has issued the current operation.
- tas_out  out  TASW  TAS value to the address generator.
- admd_out  out  ADMDW  latched address mode.
- updwn_out  out  1  latched direction.
- addr_valid  out  1  tas_out/op_idx are valid and an operation is requested.
- op_idx  out  OPW  index of the current operation at the current address.
- last_addr  out  1  the current TAS is the final address of the element.
- busy  out  1  element in progress.
- done  out  1  one-cycle pulse, the cycle after the final op_ack.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; tas_out=0; op_idx=0; admd_out=`ADMD_2I0; updwn_out=`ADDR_UP; addr_valid=0; busy=0; done=0; last_addr=0. Reset wins over every other input in the same cycle and aborts a running element immediately, with no done pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - On start: latch the three config inputs and set op_idx=0.
  - Set tas_out = 0 for UP, all-ones for DOWN.
  - Go to RUN next cycle. busy and addr_valid rise in the same cycle RUN is entered.
- RUN:
  - addr_valid=1 and busy=1.
  - On op_ack with op_idx < ops_cfg_latched: op_idx += 1; tas_out holds.
  - On op_ack with op_idx == ops_cfg_latched:
    - Not last address: op_idx=0; tas_out += 1 (UP) or -= 1 (DOWN), modulo 2^TASW.
    - Last address (tas_out all-ones for UP, 0 for DOWN): go to FIN; addr_valid drops next cycle.
  - No op_ack: hold all outputs. There is no timeout.
- FIN:
  - done=1 for exactly one cycle; busy=0; addr_valid=0.
  - Then return to IDLE. tas_out and op_idx keep their final values until the next start.
- Timing:
  - One op_ack is consumed per cycle.
  - Back-to-back acks give a throughput of 1 operation/clock.
  - Latency from start to first addr_valid: 1 cycle. From final op_ack to done: 1 cycle.
- last_addr is combinational from tas_out and updwn_out, gated by busy.
- Counter direction is applied in the TAS domain for all modes. The generator's mode-specific transform, including its own bit-MSB direction handling for AC/GC, is applied downstream and is not duplicated here.
- start while busy or in FIN: ignored, and no config is re-latched.
- start and rst in the same cycle: reset wins.
- op_ack while not in RUN: ignored.
- Config inputs change while busy: no effect.
- ops_cfg=0 gives one operation per address; all-ones gives 2^OPW operations per address.
- Element length: exactly 2^TASW × (ops_cfg+1) accepted acks.

Decomposition:
- Shared package / defines.v: `ADDR_WIDTH, `ADMD_WIDTH, `ADMD_* codes, `ADDR_UP/`ADDR_DOWN, and the state encoding constants for IDLE/RUN/FIN.
- One natural sub-module: tas_updown_counter. Loadable TASW-bit up/down counter with an enable and a terminal-count flag. Instantiated once; the FSM and op_idx counter stay in the parent.
- The address generator is instantiated by the BIST top, not inside this block.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs at reset values; a start asserted in the same cycle as rst produces no busy.
- UP linear, ops_cfg=0, op_ack held high: start with admd=`ADMD_2I0 → tas_out 0,1,…,255 on consecutive cycles; last_addr only at 255; done pulses 1 cycle after the 256th ack; busy high for exactly 256 cycles.
- DOWN, ops_cfg=2, op_ack toggling 1/0: → each address is held for 3 acks with op_idx 0,1,2; sequence 255→0; done after 768 acks; no tas change on cycles without an ack.
- Config isolation: start with admd=`ADMD_GC; mid-run drive admd_cfg=`ADMD_AC, updwn_cfg flipped, and start=1 → admd_out, updwn_out and tas progression unchanged; no restart.
- Reset mid-operation: rst at tas_out=0x40, op_idx=1 → next cycle IDLE with tas_out=0, busy=0, no done; a subsequent start runs a full element correctly.
- Back-to-back elements: start pulsed in the cycle after done → accepted; new direction latched; first addr_valid one cycle later with the correct start address.
